// File: rtl/rv32_pkg.sv
// Shared RV32 definitions: data widths, PC increment and the fetch-stage state encoding.
package rv32_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        FETCH_S_FETCH = 1'b0,
        FETCH_S_DRAIN = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/ins_fetch_fifo.sv
// Synchronous instruction buffer with flush; head is read straight from the storage registers.
module ins_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Push and pop on a full buffer is safe: the slot being overwritten is the
    // one being popped this same edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);

endmodule

// File: rtl/ins_fetch.sv
// RV32I fetch stage: PC, memory request/response tracking, redirect handling, decoder FIFO.
// Optional misaligned-redirect fault output under INS_FETCH_MISALIGN_CHK_EN.
module ins_fetch
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [ILEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            ins_valid,
    input  logic            ins_ready,
    output logic [ILEN-1:0] ins,
    output logic [XLEN-1:0] ins_pc
`ifdef INS_FETCH_MISALIGN_CHK_EN
    ,
    output logic            fetch_fault
`endif
);

    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] redirect_tgt;
    logic [OW-1:0]   outstanding;
    logic [OW-1:0]   drop_cnt;
    logic [OW-1:0]   drop_next;
    logic [OW-1:0]   drop_reload;
    logic [OW-1:0]   live;
    logic [CW-1:0]   fifo_count;
    logic            fifo_empty;
    logic            credit;
    logic            blocked;
    logic            req_fire;
    logic            push;
    logic            pop;
    fetch_state_e    state;
    fetch_state_e    state_next;

    assign redirect_tgt = redirect_pc & ~XLEN'(3);
    assign live         = outstanding - drop_cnt;
    assign credit       = (32'(live) + 32'(fifo_count) < FIFO_DEPTH)
                       && (32'(outstanding) < MAX_OUTSTANDING);

`ifdef INS_FETCH_MISALIGN_CHK_EN
    assign blocked = fetch_fault;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_fault <= 1'b0;
        end else if (redirect_valid) begin
            fetch_fault <= |redirect_pc[1:0];
        end
    end
`else
    assign blocked = 1'b0;
`endif

    assign imem_req_valid = !rst && credit && !redirect_valid && !blocked;
    assign imem_req_addr  = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses still owed to stale requests are dropped before anything is pushed.
    assign push        = imem_resp_valid && (state == FETCH_S_FETCH) && !redirect_valid;
    assign pop         = ins_valid && ins_ready && !redirect_valid;
    assign drop_reload = outstanding - OW'(imem_resp_valid);

    always_comb begin
        state_next = state;
        drop_next  = drop_cnt;
        if (redirect_valid) begin
            drop_next  = drop_reload;
            state_next = (drop_reload != '0) ? FETCH_S_DRAIN : FETCH_S_FETCH;
        end else begin
            case (state)
                FETCH_S_DRAIN: begin
                    if (imem_resp_valid) begin
                        drop_next = drop_cnt - OW'(1);
                        if (drop_cnt == OW'(1)) begin
                            state_next = FETCH_S_FETCH;
                        end
                    end
                end
                default: state_next = FETCH_S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            state       <= FETCH_S_FETCH;
        end else begin
            state       <= state_next;
            drop_cnt    <= drop_next;
            outstanding <= outstanding + OW'(req_fire) - OW'(imem_resp_valid);
            if (redirect_valid) begin
                pc      <= redirect_tgt;
                resp_pc <= redirect_tgt;
            end else begin
                if (req_fire) begin
                    pc <= pc + PC_STEP;
                end
                if (push) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
            end
        end
    end

    ins_fetch_fifo #(
        .WIDTH (ILEN + XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({imem_resp_data, resp_pc}),
        .head  ({ins, ins_pc}),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    assign ins_valid = !rst && !fifo_empty;

endmodule

// File: tb/tb_ins_fetch.sv
// Directed bench for ins_fetch with a queued instruction-memory model (1-cycle latency, stallable).
module tb_ins_fetch;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b1;
    logic [31:0] ins;
    logic [31:0] ins_pc;
`ifdef INS_FETCH_MISALIGN_CHK_EN
    logic        fetch_fault;
`endif

    logic        mem_stall = 1'b0;
    logic [31:0] mem_q[$];
    int          checks = 0;
    int          errors = 0;

    ins_fetch #(
        .RESET_PC        (32'h0000_0000),
        .FIFO_DEPTH      (2),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .ins_valid       (ins_valid),
        .ins_ready       (ins_ready),
        .ins             (ins),
        .ins_pc          (ins_pc)
`ifdef INS_FETCH_MISALIGN_CHK_EN
        ,
        .fetch_fault     (fetch_fault)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_0013;
    endfunction

    // Memory: accepts a request at edge N, returns it no earlier than edge N+1, in order.
    always @(posedge clk) begin
        if (rst) begin
            mem_q.delete();
            imem_resp_valid <= 1'b0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
            if (!mem_stall && mem_q.size() != 0) begin
                imem_resp_valid <= 1'b1;
                imem_resp_data  <= mem_word(mem_q.pop_front());
            end else begin
                imem_resp_valid <= 1'b0;
            end
        end
    end

    task automatic do_reset(input logic stall, input logic ird, input logic rrdy);
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        ins_ready = ird; imem_req_ready = rrdy; mem_stall = stall;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; redirect_valid = 1'b0; ins_ready = 1'b1; imem_req_ready = 1'b1; mem_stall = 1'b0;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid_comb: got %b expected 0", imem_req_valid); end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_ins_valid: got %b expected 0", ins_valid); end
        checks++; if (dut.pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h expected 00000000", dut.pc); end
        checks++; if (dut.outstanding !== 2'd0) begin errors++; $display("FAIL rst_outstanding: got %0d expected 0", dut.outstanding); end
        checks++; if (dut.drop_cnt !== 2'd0) begin errors++; $display("FAIL rst_drop_cnt: got %0d expected 0", dut.drop_cnt); end
        checks++; if (dut.state !== FETCH_S_FETCH) begin errors++; $display("FAIL rst_state: got %0d expected 0", dut.state); end
`ifdef INS_FETCH_MISALIGN_CHK_EN
        checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault: got %b expected 0", fetch_fault); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_pc = 32'h0;
        int nins = 0;
        do_reset(1'b0, 1'b1, 1'b1);
        for (int k = 0; k < 40; k++) begin
            if (k == 1) begin
                checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL seq_latency_early: got %b expected 0", ins_valid); end
            end
            if (k == 2) begin
                checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL seq_latency_first: got %b expected 1", ins_valid); end
            end
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL seq_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL seq_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 8) begin errors++; $display("FAIL seq_progress: got %0d expected >= 8", nins); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_pc = 32'h0;
        int nreq = 0;
        int nins = 0;
        do_reset(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 12; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL bp_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4; nreq++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nreq != 2) begin errors++; $display("FAIL bp_req_count: got %0d expected 2", nreq); end
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_stopped: got %b expected 0", imem_req_valid); end
        checks++; if (dut.fifo_count !== 2'd2) begin errors++; $display("FAIL bp_fifo_full: got %0d expected 2", dut.fifo_count); end
        ins_ready = 1'b1;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL bp_addr2: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL bp_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 6) begin errors++; $display("FAIL bp_progress: got %0d expected >= 6", nins); end
    endtask

    task automatic test_redirect_drain();
        logic [31:0] exp_addr = 32'h100;
        logic [31:0] exp_pc = 32'h100;
        int nins = 0;
        do_reset(1'b1, 1'b1, 1'b1);
        @(negedge clk); #1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rd_req_blocked: got %b expected 0", imem_req_valid); end
        checks++; if (dut.outstanding !== 2'd2) begin errors++; $display("FAIL rd_outstanding: got %0d expected 2", dut.outstanding); end
        @(negedge clk);
        redirect_valid = 1'b0; mem_stall = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 2'd2) begin errors++; $display("FAIL rd_drop_cnt: got %0d expected 2", dut.drop_cnt); end
        checks++; if (dut.state !== FETCH_S_DRAIN) begin errors++; $display("FAIL rd_state_drain: got %0d expected 1", dut.state); end
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL rd_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL rd_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 4) begin errors++; $display("FAIL rd_progress: got %0d expected >= 4", nins); end
        checks++; if (dut.state !== FETCH_S_FETCH) begin errors++; $display("FAIL rd_state_fetch: got %0d expected 0", dut.state); end
    endtask

    task automatic test_redirect_collide();
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        int nins;
        // FIFO holding pc 0, response for pc 4 arriving, decoder popping: all discarded.
        do_reset(1'b0, 1'b1, 1'b1);
        @(negedge clk); #1;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #1;
        checks++; if (ins_valid !== 1'b1) begin errors++; $display("FAIL col_pre_ins_valid: got %b expected 1", ins_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL col_flushed: got %b expected 0", ins_valid); end
        checks++; if (dut.drop_cnt !== 2'd0) begin errors++; $display("FAIL col_drop_cnt: got %0d expected 0", dut.drop_cnt); end
        checks++; if (dut.state !== FETCH_S_FETCH) begin errors++; $display("FAIL col_state: got %0d expected 0", dut.state); end
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h40}) begin errors++; $display("FAIL col_req: got %b/%h expected 1/00000040", imem_req_valid, imem_req_addr); end

        // Two outstanding, one arriving with the redirect: one left to drop while requests continue.
        do_reset(1'b1, 1'b1, 1'b1);
        @(negedge clk); #1;
        @(negedge clk);
        mem_stall = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 32'h60;
        #1;
        checks++; if (dut.outstanding !== 2'd2) begin errors++; $display("FAIL col2_outstanding: got %0d expected 2", dut.outstanding); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if (dut.drop_cnt !== 2'd1) begin errors++; $display("FAIL col2_drop_cnt: got %0d expected 1", dut.drop_cnt); end
        checks++; if (dut.state !== FETCH_S_DRAIN) begin errors++; $display("FAIL col2_state: got %0d expected 1", dut.state); end
        checks++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h60}) begin errors++; $display("FAIL col2_req_in_drain: got %b/%h expected 1/00000060", imem_req_valid, imem_req_addr); end
        exp_addr = 32'h60; exp_pc = 32'h60; nins = 0;
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL col2_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL col2_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 4) begin errors++; $display("FAIL col2_progress: got %0d expected >= 4", nins); end
    endtask

    task automatic test_req_stall();
        logic [31:0] exp_addr = 32'h0;
        logic [31:0] exp_pc = 32'h0;
        int nins = 0;
        do_reset(1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++; if ({imem_req_valid, imem_req_addr, dut.pc} !== {1'b1, 32'h0, 32'h0}) begin errors++; $display("FAIL stall_hold: got %b/%h/%h expected 1/00000000/00000000", imem_req_valid, imem_req_addr, dut.pc); end
            @(negedge clk); #1;
        end
        imem_req_ready = 1'b1;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL stall_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL stall_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 4) begin errors++; $display("FAIL stall_progress: got %0d expected >= 4", nins); end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr = 32'hFFFF_FFF8;
        logic [31:0] exp_pc = 32'hFFFF_FFF8;
        int nins = 0;
        do_reset(1'b0, 1'b1, 1'b1);
        redirect_valid = 1'b1;
`ifdef INS_FETCH_MISALIGN_CHK_EN
        redirect_pc = 32'hFFFF_FFF8;
`else
        redirect_pc = 32'hFFFF_FFFB;
`endif
        #1;
        checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL wrap_req_blocked: got %b expected 0", imem_req_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        for (int k = 0; k < 30; k++) begin
            if (imem_req_valid && imem_req_ready) begin
                checks++; if (imem_req_addr !== exp_addr) begin errors++; $display("FAIL wrap_addr: got %h expected %h", imem_req_addr, exp_addr); end
                exp_addr += 32'd4;
            end
            if (ins_valid && ins_ready) begin
                checks++; if ({ins, ins_pc} !== {mem_word(exp_pc), exp_pc}) begin errors++; $display("FAIL wrap_ins: got %h/%h expected %h/%h", ins, ins_pc, mem_word(exp_pc), exp_pc); end
                exp_pc += 32'd4; nins++;
            end
            @(negedge clk); #1;
        end
        checks++; if (nins < 5) begin errors++; $display("FAIL wrap_progress: got %0d expected >= 5", nins); end
    endtask

`ifdef INS_FETCH_MISALIGN_CHK_EN
    task automatic test_misalign();
        do_reset(1'b0, 1'b1, 1'b1);
        redirect_valid = 1'b1; redirect_pc = 32'h102;
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if ({fetch_fault, imem_req_valid} !== 2'b10) begin errors++; $display("FAIL mis_fault_block: got %b%b expected 10", fetch_fault, imem_req_valid); end
            @(negedge clk); #1;
        end
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        #1;
        checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL mis_sticky: got %b expected 1", fetch_fault); end
        @(negedge clk);
        redirect_valid = 1'b0;
        #1;
        checks++; if ({fetch_fault, imem_req_valid, imem_req_addr} !== {2'b01, 32'h200}) begin errors++; $display("FAIL mis_clear: got %b%b/%h expected 01/00000200", fetch_fault, imem_req_valid, imem_req_addr); end
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_reset();
        test_redirect_drain();
        test_redirect_collide();
        test_req_stall();
        test_wrap();
`ifdef INS_FETCH_MISALIGN_CHK_EN
        test_misalign();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
